// File: rtl/fetch_ctrl_if.sv
// Bundle of fetch_ctrl handshake signals: pipeline control, instruction-memory
// req/ack bus and the decode-side outputs.
interface fetch_ctrl_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_old;
    logic        misalign;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc, pc_old, misalign
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_old, misalign
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Redirect-aware instruction-fetch sequencer: owns the PC, runs the imem req/ack
// loop and holds one instruction for decode. FETCH_ALIGN_CHECK_EN enables the misalign trap.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          res,
    fetch_ctrl_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_old;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_kill;
    logic        r_misalign;

    logic [1:0]  w_state_nx;
    logic [31:0] w_pc_nx;
    logic [31:0] w_pc_old_nx;
    logic [31:0] w_instr_nx;
    logic        w_valid_nx;
    logic        w_kill_nx;
    logic        w_mis_nx;
    logic [31:0] w_tgt;
    logic        w_bad;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_tgt = bus.redirect_pc;
    assign w_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign w_tgt = {bus.redirect_pc[31:2], 2'b00};
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_pc_old_nx = r_pc_old;
        w_instr_nx  = r_instr;
        w_valid_nx  = r_valid;
        w_kill_nx   = r_kill;
        w_mis_nx    = r_misalign;
        case (r_state)
            S_IDLE: begin
                w_state_nx = S_FETCH;
                if (bus.redirect) begin
                    w_pc_nx  = w_tgt;
                    w_mis_nx = w_bad;
                    if (w_bad) w_state_nx = S_TRAP;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    w_pc_nx  = w_tgt;
                    w_mis_nx = w_bad;
                    // Ack in the same cycle drains the request, so nothing is left to kill.
                    if (bus.imem_ack) begin
                        w_kill_nx = 1'b0;
                        if (w_bad) w_state_nx = S_TRAP;
                    end else begin
                        w_kill_nx = 1'b1;
                    end
                end else if (bus.imem_ack) begin
                    if (r_kill) begin
                        w_kill_nx = 1'b0;
                        if (r_misalign) w_state_nx = S_TRAP;
                    end else begin
                        w_instr_nx  = bus.imem_rdata;
                        w_pc_old_nx = r_pc;
                        w_pc_nx     = r_pc + 32'd4;
                        w_valid_nx  = 1'b1;
                        w_state_nx  = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (bus.redirect) begin
                    w_pc_nx    = w_tgt;
                    w_mis_nx   = w_bad;
                    w_valid_nx = 1'b0;
                    w_instr_nx = NOP_INSTR;
                    w_state_nx = w_bad ? S_TRAP : S_FETCH;
                end else if (!bus.stall) begin
                    w_valid_nx = 1'b0;
                    w_instr_nx = NOP_INSTR;
                    w_state_nx = S_FETCH;
                end
            end
            S_TRAP: begin
                if (bus.redirect) begin
                    w_pc_nx  = w_tgt;
                    w_mis_nx = w_bad;
                    if (!w_bad) w_state_nx = S_FETCH;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_old   <= 32'h0;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_kill     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_pc_old   <= w_pc_old_nx;
            r_instr    <= w_instr_nx;
            r_valid    <= w_valid_nx;
            r_kill     <= w_kill_nx;
            r_misalign <= w_mis_nx;
        end
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.pc_old      = r_pc_old;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.misalign    = r_misalign;

endmodule
